instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch state encoding, reset/NOP constants and
// immediate-source selectors used by decode.
package rv32i_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    localparam logic [2:0] IMM_SRC_I = 3'd0;
    localparam logic [2:0] IMM_SRC_S = 3'd1;
    localparam logic [2:0] IMM_SRC_B = 3'd2;
    localparam logic [2:0] IMM_SRC_U = 3'd3;
    localparam logic [2:0] IMM_SRC_J = 3'd4;

    // Clears the byte offset so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit with redirect handling and a
// one-entry hold buffer toward decode.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_q;
    logic [31:0] discard_addr_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [31:0] fetch_count_q;
    logic [31:0] redirect_target;
    logic        accept;

    assign redirect_target = word_align(redirect_pc);
    assign accept          = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    state_d = imem_rvalid ? S_FETCH : S_DISCARD;
                end else if (imem_rvalid) begin
                    state_d = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = 32'h0000_0000;
        instr_valid = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
            end
            S_DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = discard_addr_q;
            end
            S_HOLD: begin
                instr_valid = !redirect_valid;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // Redirects retarget pc immediately; the in-flight address is parked in
    // discard_addr_q so the memory sees a stable request until it answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            discard_addr_q <= 32'h0000_0000;
            instr_q        <= NOP_INSTR;
            instr_pc_q     <= 32'h0000_0000;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_target;
                        if (!imem_rvalid) begin
                            discard_addr_q <= pc_q;
                        end
                    end else if (imem_rvalid) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                    end
                end
                S_DISCARD: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_target;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_target;
                    end else if (instr_ready) begin
                        pc_q <= instr_pc_q + PC_STEP;
                    end
                end
                default: begin
                    pc_q <= pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'h0000_0000;
        end else if (accept) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a transaction-level
// model of request/response/hold behaviour.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    int compared;
    int mismatched;

    // Reference model: "started" after the first idle cycle, "pending" while a
    // request is in flight, "stale" when that in-flight answer must be dropped.
    bit          m_started;
    bit          m_pending;
    bit          m_stale;
    bit          m_full;
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    logic [31:0] m_instr;
    logic [31:0] m_instr_pc;
    logic [31:0] m_count;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_started  = 1'b0;
        m_pending  = 1'b0;
        m_stale    = 1'b0;
        m_full     = 1'b0;
        m_pc       = 32'h0000_0000;
        m_req_addr = 32'h0000_0000;
        m_instr    = 32'h0000_0013;
        m_instr_pc = 32'h0000_0000;
        m_count    = 32'h0000_0000;
    endtask

    task automatic modelStep(input bit rv, input logic [31:0] rd, input bit redir,
                             input logic [31:0] rpc, input bit ready);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (!m_started) begin
            m_started  = 1'b1;
            m_pending  = 1'b1;
            m_stale    = 1'b0;
            m_req_addr = m_pc;
        end else if (m_pending) begin
            if (m_stale) begin
                if (redir) m_pc = tgt;
                if (rv) begin
                    m_stale    = 1'b0;
                    m_req_addr = m_pc;
                end
            end else if (redir) begin
                m_pc = tgt;
                if (rv) m_req_addr = m_pc;
                else    m_stale = 1'b1;
            end else if (rv) begin
                m_instr    = rd;
                m_instr_pc = m_req_addr;
                m_full     = 1'b1;
                m_pending  = 1'b0;
            end
        end else if (m_full) begin
            if (redir) begin
                m_pc       = tgt;
                m_full     = 1'b0;
                m_pending  = 1'b1;
                m_req_addr = m_pc;
            end else if (ready) begin
                m_pc       = m_instr_pc + 32'd4;
                m_count    = m_count + 32'd1;
                m_full     = 1'b0;
                m_pending  = 1'b1;
                m_req_addr = m_pc;
            end
        end
    endtask

    task automatic checkAgainstModel(input bit redir);
        checkOutput("imem_req",    {31'd0, imem_req},    {31'd0, m_pending});
        checkOutput("imem_addr",   imem_addr,            m_pending ? m_req_addr : 32'h0);
        checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, m_full && !redir});
        checkOutput("instr",       instr,                m_instr);
        checkOutput("instr_pc",    instr_pc,             m_instr_pc);
        checkOutput("fetch_count", fetch_count,          m_count);
    endtask

    // Called at a falling edge: drive, compare, advance model, wait one cycle.
    task automatic applyStimulus(input bit rv, input logic [31:0] rd, input bit redir,
                                 input logic [31:0] rpc, input bit ready);
        imem_rvalid    = rv;
        imem_rdata     = rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = ready;
        #1;
        checkAgainstModel(redir);
        modelStep(rv, rd, redir, rpc, ready);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"},   {31'd0, imem_req},    32'h0);
        checkOutput({tag, "_addr"},  imem_addr,            32'h0);
        checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'h0);
        checkOutput({tag, "_instr"}, instr,                32'h0000_0013);
        checkOutput({tag, "_pc"},    instr_pc,             32'h0);
        checkOutput({tag, "_count"}, fetch_count,          32'h0);
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        rst_n          = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        modelReset();
        repeat (3) @(negedge clk);
        checkResetValues("reset");

        // First fetch from RESET_PC with a zero-wait memory.
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("first_addr", imem_addr, 32'h0);
        applyStimulus(1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b1);
        checkOutput("first_instr", instr, 32'h0050_0093);
        checkOutput("first_ipc", instr_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("second_addr", imem_addr, 32'h4);

        // Decode stalls for five cycles while an instruction is held.
        applyStimulus(1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_count", fetch_count, 32'd2);

        // Redirect to an unaligned target while the fetch at 0x8 waits.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("discard_addr", imem_addr, 32'h8);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        checkOutput("redirect_addr", imem_addr, 32'h100);
        applyStimulus(1'b1, 32'h0000_0033, 1'b0, 32'h0, 1'b1);

        // Redirect during hold suppresses the handshake.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b1);
        checkOutput("hold_redir_addr", imem_addr, 32'h40);
        checkOutput("hold_redir_count", fetch_count, 32'd2);

        // Address and counter wrap-around.
        applyStimulus(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
        dut.fetch_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        applyStimulus(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_count", fetch_count, 32'h0);

        // Asynchronous reset while a request is outstanding.
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        modelReset();
        imem_rvalid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'hCAFE_0001, 1'b0, 32'h0, 1'b1);
        checkOutput("restart_addr", imem_addr, 32'h0);

        // Random traffic: variable latency, stray responses, redirects, stalls.
        for (int i = 0; i < 3000; i++) begin
            bit          rv;
            bit          redir;
            bit          ready;
            logic [31:0] rd;
            logic [31:0] rpc;
            rv    = m_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 7) == 0);
            ready = ($urandom_range(0, 3) != 0);
            rd    = $urandom;
            rpc   = $urandom;
            applyStimulus(rv, rd, redir, rpc, ready);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
